// File: rtl/bram_port_arbiter.sv
// Shares one simple-dual-port block RAM among N_REQ requesters: independent round-robin
// arbiters for the write port (a) and the read port (b), read data tagged back via rvalid.
module bram_port_arbiter #(
    parameter int ADDR_WIDTH = 14,
    parameter int N_REQ      = 3
) (
    input  logic                        clka,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ-1:0]            req_we,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [N_REQ*32-1:0]         req_wdata,
    input  logic [N_REQ*4-1:0]          req_wstrb,
    output logic [N_REQ-1:0]            gnt,
    output logic [N_REQ-1:0]            rvalid,
    output logic [31:0]                 rdata,
    output logic [ADDR_WIDTH-1:0]       bram_addra,
    output logic [31:0]                 bram_dina,
    output logic [3:0]                  bram_wea,
    output logic [ADDR_WIDTH-1:0]       bram_addrb,
    input  logic [31:0]                 bram_doutb
);

    localparam int PW = $clog2(N_REQ);
    typedef logic [PW-1:0] ptr_t;

    logic [N_REQ-1:0] wr_cand;
    logic [N_REQ-1:0] rd_cand;
    logic [N_REQ-1:0] wr_oh;
    logic [N_REQ-1:0] rd_oh;
    ptr_t             wr_last_q, wr_last_d;
    ptr_t             rd_last_q, rd_last_d;
    logic [N_REQ-1:0] rvalid_q, rvalid_d;

    // Search starts one past the last winner and wraps, so the last winner has lowest priority.
    function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] cand, input ptr_t last);
        logic [N_REQ-1:0] oh;
        logic             found;
        int               idx;
        oh    = '0;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = int'(last) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && cand[ptr_t'(idx)]) begin
                oh[ptr_t'(idx)] = 1'b1;
                found           = 1'b1;
            end
        end
        return oh;
    endfunction

    function automatic ptr_t oh_to_idx(input logic [N_REQ-1:0] oh);
        ptr_t idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | ptr_t'(i);
            end
        end
        return idx;
    endfunction

    always_comb begin
        // Masking candidates under reset guarantees no grant and idle RAM ports while rst is high.
        wr_cand = rst ? '0 : (req & req_we);
        rd_cand = rst ? '0 : (req & ~req_we);
        wr_oh   = rr_pick(wr_cand, wr_last_q);
        rd_oh   = rr_pick(rd_cand, rd_last_q);
        gnt     = wr_oh | rd_oh;

        wr_last_d = (|wr_oh) ? oh_to_idx(wr_oh) : wr_last_q;
        rd_last_d = (|rd_oh) ? oh_to_idx(rd_oh) : rd_last_q;
        rvalid_d  = rd_oh;

        bram_addra = '0;
        bram_dina  = '0;
        bram_wea   = '0;
        bram_addrb = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (wr_oh[i]) begin
                bram_addra = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                bram_dina  = req_wdata[i*32 +: 32];
                bram_wea   = req_wstrb[i*4 +: 4];
            end
            if (rd_oh[i]) begin
                bram_addrb = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            wr_last_q <= ptr_t'(N_REQ - 1);
            rd_last_q <= ptr_t'(N_REQ - 1);
            rvalid_q  <= '0;
        end else begin
            wr_last_q <= wr_last_d;
            rd_last_q <= rd_last_d;
            rvalid_q  <= rvalid_d;
        end
    end

    // RAM read is registered inside the BRAM, so its output already lines up with rvalid_q.
    assign rvalid = rvalid_q;
    assign rdata  = bram_doutb;

endmodule
